// File: rtl/matmul_pkg.sv
// Shared widths, byte counts and controller state encoding for the
// byte-serial 3x3 matrix-multiply front-end.
package matmul_pkg;

    localparam int ELEM_W      = 8;                 // A/B element width
    localparam int C_W         = 18;                // result element width
    localparam int N_ELEM      = 9;                 // elements per matrix
    localparam int IN_BYTES    = 18;                // A then B
    localparam int OUT_BYTES   = 27;                // 9 results x 3 bytes
    localparam int BYTES_PER_C = 3;

    localparam int MAT_W = ELEM_W * N_ELEM;         // packed A or B
    localparam int RES_W = C_W * N_ELEM;            // packed C

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN
    } state_t;

endpackage

// File: rtl/matmul_out_ser.sv
// Result capture and byte serialiser: holds C0..C8 and streams them out
// as 27 bytes, LSB first per element, over a valid/ready handshake.
module matmul_out_ser
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_capture,
    input  logic [RES_W-1:0]  i_result,
    input  logic              i_out_ready,
    output logic [7:0]        o_out_data,
    output logic              o_out_valid,
    output logic              o_last
);

    localparam logic [4:0] OUT_LAST = 5'(OUT_BYTES - 1);

    logic [RES_W-1:0] r_result;
    logic [4:0]       r_drain_cnt;
    logic             r_out_valid;
    logic [7:0]       w_bytes [OUT_BYTES];

    // Capture the datapath result when the sequencer sees mm_done.
    // NOTE: pure data register with no reset; it is only observable through
    // o_out_data, which is forced to zero whenever o_out_valid is low.
    always_ff @(posedge clk) begin
        if (i_capture) begin
            r_result <= i_result;
        end
    end

    // Drain counter and valid flag; clear wins over capture and transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drain_cnt <= '0;
            r_out_valid <= 1'b0;
        end else if (i_clear) begin
            r_drain_cnt <= '0;
            r_out_valid <= 1'b0;
        end else if (i_capture) begin
            r_drain_cnt <= '0;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && i_out_ready) begin
            if (r_drain_cnt == OUT_LAST) begin
                r_drain_cnt <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_drain_cnt <= r_drain_cnt + 5'd1;
            end
        end
    end

    // Split each 18-bit element into low, middle and zero-padded top byte.
    always_comb begin
        for (int j = 0; j < N_ELEM; j++) begin
            w_bytes[BYTES_PER_C*j]     = r_result[C_W*j +: 8];
            w_bytes[BYTES_PER_C*j + 1] = r_result[C_W*j + 8 +: 8];
            w_bytes[BYTES_PER_C*j + 2] = {6'b0, r_result[C_W*j + 16 +: 2]};
        end
    end

    // Count only moves on an accepted byte, so data holds during a stall.
    assign o_out_data  = r_out_valid ? w_bytes[r_drain_cnt] : 8'd0;
    assign o_out_valid = r_out_valid;
    assign o_last      = r_out_valid && i_out_ready && (r_drain_cnt == OUT_LAST);

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Byte-serial front-end and sequencer for the 3x3 matrix_mult datapath:
// loads A then B, runs the datapath with a done timeout, then drains C.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DONE_TIMEOUT = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [ELEM_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               error,
    output logic [MAT_W-1:0]   mm_a,
    output logic [MAT_W-1:0]   mm_b,
    output logic               mm_enable,
    input  logic [RES_W-1:0]   mm_c,
    input  logic               mm_done
);

    localparam logic [3:0] LOAD_LAST = 4'(IN_BYTES / 2 - 1);
    localparam logic [2:0] TO_LAST   = 3'(DONE_TIMEOUT - 1);

    state_t           r_state;
    logic [3:0]       r_load_cnt;
    logic [2:0]       r_to_cnt;
    logic             r_in_ready;
    logic             r_mm_enable;
    logic             r_error;
    logic [MAT_W-1:0] r_mm_a;
    logic [MAT_W-1:0] r_mm_b;

    logic             w_accept;
    logic             w_capture;
    logic             w_drain_last;

    assign w_accept  = in_valid && r_in_ready;
    assign w_capture = (r_state == COMPUTE) && mm_done && !clear;

    // Sequencer: load path, datapath enable, timeout and sticky error.
    // NOTE: every register here uses <= so all next-state values are computed
    // from the same pre-edge snapshot, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= LOAD_A;
            r_load_cnt  <= '0;
            r_to_cnt    <= '0;
            r_in_ready  <= 1'b0;
            r_mm_enable <= 1'b0;
            r_error     <= 1'b0;
            r_mm_a      <= '0;
            r_mm_b      <= '0;
        end else if (clear) begin
            r_state     <= LOAD_A;
            r_load_cnt  <= '0;
            r_to_cnt    <= '0;
            r_in_ready  <= 1'b1;
            r_mm_enable <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_mm_a[{r_load_cnt, 3'b000} +: ELEM_W] <= in_data;
                        if (r_load_cnt == LOAD_LAST) begin
                            r_load_cnt <= '0;
                            r_state    <= LOAD_B;
                        end else begin
                            r_load_cnt <= r_load_cnt + 4'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        r_mm_b[{r_load_cnt, 3'b000} +: ELEM_W] <= in_data;
                        if (r_load_cnt == LOAD_LAST) begin
                            r_load_cnt  <= '0;
                            r_to_cnt    <= '0;
                            r_in_ready  <= 1'b0;
                            r_mm_enable <= 1'b1;
                            r_state     <= COMPUTE;
                        end else begin
                            r_load_cnt <= r_load_cnt + 4'd1;
                        end
                    end
                end
                COMPUTE: begin
                    if (mm_done) begin
                        r_mm_enable <= 1'b0;
                        r_state     <= DRAIN;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_error     <= 1'b1;
                        r_mm_enable <= 1'b0;
                        r_to_cnt    <= '0;
                        r_in_ready  <= 1'b1;
                        r_state     <= LOAD_A;
                    end else begin
                        r_to_cnt <= r_to_cnt + 3'd1;
                    end
                end
                DRAIN: begin
                    if (w_drain_last) begin
                        r_in_ready <= 1'b1;
                        r_state    <= LOAD_A;
                    end
                end
                default: begin
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

    matmul_out_ser u_out_ser (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (clear),
        .i_capture   (w_capture),
        .i_result    (mm_c),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .o_last      (w_drain_last)
    );

    assign in_ready  = r_in_ready;
    assign busy      = (r_state == COMPUTE) || (r_state == DRAIN);
    assign error     = r_error;
    assign mm_a      = r_mm_a;
    assign mm_b      = r_mm_b;
    assign mm_enable = r_mm_enable;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl with a stub datapath that raises
// mm_done three cycles after mm_enable rises (or never, when hung).
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             clear     = 1'b0;
    logic [7:0]       in_data   = 8'd0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             error;
    logic [MAT_W-1:0] mm_a;
    logic [MAT_W-1:0] mm_b;
    logic             mm_enable;
    logic [RES_W-1:0] mm_c;
    logic             mm_done;

    logic [2:0]       dp_cnt;
    logic             dp_hang = 1'b0;
    logic [17:0]      acc;

    logic [7:0]       mat_a [9];
    logic [7:0]       mat_b [9];
    logic [7:0]       exp_bytes [27];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.DONE_TIMEOUT(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .error     (error),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_enable (mm_enable),
        .mm_c      (mm_c),
        .mm_done   (mm_done)
    );

    // Stub datapath: counts enabled cycles, done on the fourth enabled cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          dp_cnt <= 3'd0;
        else if (!mm_enable) dp_cnt <= 3'd0;
        else if (dp_cnt != 3'd7) dp_cnt <= dp_cnt + 3'd1;
    end
    assign mm_done = mm_enable && !dp_hang && (dp_cnt == 3'd3);

    // Stub datapath product C = A x B, row-major.
    always_comb begin
        mm_c = '0;
        acc  = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = '0;
                for (int k = 0; k < 3; k++) begin
                    acc = acc + 18'(mm_a[8*(3*i+k) +: 8]) * 18'(mm_b[8*(3*k+j) +: 8]);
                end
                mm_c[18*(3*i+j) +: 18] = acc;
            end
        end
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fail_now(input string tag);
        n_total++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) fail_now("in_ready_wait");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input bit gap);
        for (int k = 0; k < 18; k++) begin
            if (k < 9) send_byte(mat_a[k]);
            else       send_byte(mat_b[k-9]);
            if (gap && k < 17) begin
                check("gap_en_low", mm_enable, 0);
                @(posedge clk); #1;
            end
        end
    endtask

    // mode 0: always ready; mode 1: ready one cycle in three.
    task automatic recv(input int mode, input int n);
        int got = 0;
        int cyc = 0;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [7:0] pd = 8'd0;
        logic v, r;
        logic [7:0] d;
        while (got < n && cyc < 400) begin
            out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            v = out_valid;
            r = out_ready;
            d = out_data;
            if (pv && !pr) begin
                check("stall_valid", v, 1);
                check("stall_data", d, pd);
            end
            @(posedge clk); #1;
            if (v && r) begin
                check($sformatf("out_byte%0d", got), d, exp_bytes[got]);
                got++;
            end
            pv = v;
            pr = r;
            pd = d;
            cyc++;
        end
        out_ready = 1'b0;
        if (got < n) fail_now("recv_bytes");
    endtask

    task automatic set_identity_ab();
        for (int k = 0; k < 9; k++) begin
            mat_a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
            mat_b[k] = 8'(k + 1);
        end
        for (int k = 0; k < 27; k++) exp_bytes[k] = (k % 3 == 0) ? 8'(k/3 + 1) : 8'h00;
    endtask

    task automatic set_all_ff();
        for (int k = 0; k < 9; k++) begin
            mat_a[k] = 8'hFF;
            mat_b[k] = 8'hFF;
        end
        for (int k = 0; k < 27; k++)
            exp_bytes[k] = (k % 3 == 0) ? 8'h03 : ((k % 3 == 1) ? 8'hFA : 8'h02);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset is held.
        #3 reset = 1'b0;
        #10;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_mm_enable", mm_enable, 0);
        check("rst_mm_a", mm_a, 0);
        check("rst_mm_b", mm_b, 0);
        #3 reset = 1'b1;
        check("ready_low_after_rst", in_ready, 0);
        @(posedge clk); #1;
        check("ready_high_after_rst", in_ready, 1);

        // Identity x (1..9), sink always ready.
        set_identity_ab();
        load(1'b0);
        check("t1_mm_a", mm_a, 72'h010000000100000001);
        check("t1_mm_b", mm_b, 72'h090807060504030201);
        check("t1_en", mm_enable, 1);
        check("t1_ready_low", in_ready, 0);
        check("t1_busy", busy, 1);
        recv(0, 27);
        check("t1_valid_end", out_valid, 0);
        check("t1_busy_end", busy, 0);
        check("t1_ready_end", in_ready, 1);

        // All 0xFF; enable window from load end to the cycle after done.
        set_all_ff();
        load(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t2_en_high", mm_enable, 1);
            @(posedge clk); #1;
        end
        check("t2_en_low", mm_enable, 0);
        check("t2_valid", out_valid, 1);
        check("t2_busy", busy, 1);
        recv(0, 27);
        check("t2_error", error, 0);
        check("t2_busy_end", busy, 0);

        // Identity again with the sink ready one cycle in three.
        set_identity_ab();
        load(1'b0);
        recv(1, 27);
        check("t3_valid_end", out_valid, 0);

        // Gapped input; B = 9..1 so C equals B.
        for (int k = 0; k < 9; k++) mat_b[k] = 8'(9 - k);
        for (int k = 0; k < 27; k++) exp_bytes[k] = (k % 3 == 0) ? 8'(9 - k/3) : 8'h00;
        load(1'b1);
        check("t4_en_after_18", mm_enable, 1);
        check("t4_mm_b", mm_b, 72'h010203040506070809);
        recv(0, 27);

        // Hung datapath: abort after seven enabled cycles.
        dp_hang = 1'b1;
        set_identity_ab();
        load(1'b0);
        for (int i = 0; i < 7; i++) begin
            check("t5_en_wait", mm_enable, 1);
            check("t5_err_wait", error, 0);
            @(posedge clk); #1;
        end
        check("t5_error", error, 1);
        check("t5_en_low", mm_enable, 0);
        check("t5_ready", in_ready, 1);
        check("t5_busy", busy, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t5_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("t5_error_sticky", error, 1);
        dp_hang = 1'b0;

        // Clear on the fifth B byte drops that byte and restarts at A.
        for (int k = 0; k < 9; k++) send_byte(8'hA0 + 8'(k));
        for (int k = 0; k < 4; k++) send_byte(8'hB0 + 8'(k));
        in_data  = 8'h55;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t6_err_cleared", error, 0);
        check("t6_ready", in_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_en", mm_enable, 0);
        set_identity_ab();
        load(1'b0);
        check("t6_mm_a", mm_a, 72'h010000000100000001);
        check("t6_mm_b", mm_b, 72'h090807060504030201);
        recv(0, 10);
        check("t6_byte10_valid", out_valid, 1);
        check("t6_byte10_data", out_data, exp_bytes[10]);

        // Asynchronous reset in the middle of the drain.
        #2 reset = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_en", mm_enable, 0);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_mm_a", mm_a, 0);
        check("t6_rst_mm_b", mm_b, 0);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        check("t6_ready_again", in_ready, 1);

        // Fresh load after the reset completes normally.
        set_all_ff();
        load(1'b0);
        check("t6_mm_a_ff", mm_a, {9{8'hFF}});
        recv(0, 27);
        check("t6_busy_end", busy, 0);
        check("t6_ready_end", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
